// File: rtl/execute_stage.sv
// Execute stage: ID/EX operand capture, combinational ALU, EX/MEM result register.
// Define EX_FORWARD_EN to bypass the EX/MEM result into the ALU operands.
module execute_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic [DATA_W-1:0]     dataReg1,
  input  logic [DATA_W-1:0]     dataReg2,
  input  logic [REG_ADDR_W-1:0] dataS1AddrIn,
  input  logic [REG_ADDR_W-1:0] dataS2AddrIn,
  input  logic [REG_ADDR_W-1:0] writeBackAddrIn,
  input  logic [3:0]            ALUop,
  input  logic [DATA_W-1:0]     immValueIn,
  input  logic [1:0]            dataCacheControlIn,
  input  logic                  writeEnableReg,
  output logic [DATA_W-1:0]     dataOut,
  output logic [DATA_W-1:0]     dataRs2Out,
  output logic [1:0]            dataCacheControlOut,
  output logic                  writeEnableOut,
  output logic [REG_ADDR_W-1:0] writeBackAddrOut
);

  // ID/EX
  logic [DATA_W-1:0]     rs1_q, rs2_q, imm_q;
  logic [REG_ADDR_W-1:0] rs1_addr_q, rs2_addr_q, rd_q;
  logic [3:0]            op_q;
  logic [1:0]            ctl_q;
  logic                  we_q;

  // EX/MEM
  logic [DATA_W-1:0]     res_q, st_q;
  logic [REG_ADDR_W-1:0] rd_mem_q;
  logic [1:0]            ctl_mem_q;
  logic                  we_mem_q;

  logic [DATA_W-1:0]     a, b, res_d;
  logic [1:0]            ctl_d;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rs1_q      <= '0;
      rs2_q      <= '0;
      imm_q      <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_q       <= '0;
      op_q       <= '0;
      ctl_q      <= '0;
      we_q       <= 1'b0;
    end else begin
      rs1_q      <= dataReg1;
      rs2_q      <= dataReg2;
      imm_q      <= immValueIn;
      rs1_addr_q <= dataS1AddrIn;
      rs2_addr_q <= dataS2AddrIn;
      rd_q       <= writeBackAddrIn;
      op_q       <= ALUop;
      ctl_q      <= dataCacheControlIn;
      we_q       <= writeEnableReg;
    end
  end

`ifdef EX_FORWARD_EN
  logic fwd1, fwd2;
  // Bypass only a real register write; x0 is never a valid producer.
  assign fwd1 = we_mem_q && (rd_mem_q != '0) && (rd_mem_q == rs1_addr_q);
  assign fwd2 = we_mem_q && (rd_mem_q != '0) && (rd_mem_q == rs2_addr_q);
  assign a    = fwd1 ? res_q : rs1_q;
  assign b    = fwd2 ? res_q : rs2_q;
`else
  logic unused_addr;
  assign unused_addr = ^{rs1_addr_q, rs2_addr_q};
  assign a = rs1_q;
  assign b = rs2_q;
`endif

  always_comb begin
    res_d = '0;
    case (op_q)
      4'h0: res_d = a + b;
      4'h1: res_d = a - b;
      4'h2: res_d = a & b;
      4'h3: res_d = a | b;
      4'h4: res_d = a ^ b;
      4'h5: res_d = a << b[4:0];
      4'h6: res_d = a >> b[4:0];
      4'h7: res_d = $signed(a) >>> b[4:0];
      4'h8: res_d = DATA_W'($signed(a) < $signed(b));
      4'h9: res_d = DATA_W'(a < b);
      4'hA: res_d = a + imm_q;
      4'hB: res_d = a & imm_q;
      4'hC: res_d = a | imm_q;
      4'hD: res_d = a ^ imm_q;
      4'hE: res_d = DATA_W'($signed(a) < $signed(imm_q));
      default: res_d = imm_q;
    endcase
  end

  // The reserved encoding leaves the stage as a plain "no access".
  assign ctl_d = (ctl_q == 2'b11) ? 2'b00 : ctl_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      res_q     <= '0;
      st_q      <= '0;
      ctl_mem_q <= '0;
      we_mem_q  <= 1'b0;
      rd_mem_q  <= '0;
    end else begin
      res_q     <= res_d;
      st_q      <= b;
      ctl_mem_q <= ctl_d;
      we_mem_q  <= we_q;
      rd_mem_q  <= rd_q;
    end
  end

  assign dataOut             = res_q;
  assign dataRs2Out          = st_q;
  assign dataCacheControlOut = ctl_mem_q;
  assign writeEnableOut      = we_mem_q;
  assign writeBackAddrOut    = rd_mem_q;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed vectors plus random traffic
// against an instruction-level reference model.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        resetN;
  logic [31:0] dataReg1, dataReg2, immValueIn;
  logic [4:0]  dataS1AddrIn, dataS2AddrIn, writeBackAddrIn;
  logic [3:0]  ALUop;
  logic [1:0]  dataCacheControlIn;
  logic        writeEnableReg;
  logic [31:0] dataOut, dataRs2Out;
  logic [1:0]  dataCacheControlOut;
  logic        writeEnableOut;
  logic [4:0]  writeBackAddrOut;

  int n_checks = 0;
  int n_fail   = 0;

  execute_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .resetN(resetN),
    .dataReg1(dataReg1), .dataReg2(dataReg2),
    .dataS1AddrIn(dataS1AddrIn), .dataS2AddrIn(dataS2AddrIn),
    .writeBackAddrIn(writeBackAddrIn), .ALUop(ALUop),
    .immValueIn(immValueIn), .dataCacheControlIn(dataCacheControlIn),
    .writeEnableReg(writeEnableReg),
    .dataOut(dataOut), .dataRs2Out(dataRs2Out),
    .dataCacheControlOut(dataCacheControlOut),
    .writeEnableOut(writeEnableOut), .writeBackAddrOut(writeBackAddrOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r1, r2, imm;
    logic [4:0]  a1, a2, rd;
    logic [3:0]  op;
    logic [1:0]  ctl;
    logic        we;
  } instr_t;

  typedef struct {
    logic [31:0] d, st;
    logic [1:0]  ctl;
    logic        we;
    logic [4:0]  rd;
  } exp_t;

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] i);
    int sh;
    sh = int'(b % 32);
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return a << sh;
      4'h6: return a >> sh;
      4'h7: return 32'($signed(a) >>> sh);
      4'h8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h9: return (a < b) ? 32'd1 : 32'd0;
      4'hA: return a + i;
      4'hB: return a & i;
      4'hC: return a | i;
      4'hD: return a ^ i;
      4'hE: return ($signed(a) < $signed(i)) ? 32'd1 : 32'd0;
      default: return i;
    endcase
  endfunction

  // Result of one instruction given the result of the instruction issued just before it.
  function automatic exp_t predict(input instr_t in, input exp_t prev);
    exp_t e;
    logic [31:0] a, b;
    a = in.r1;
    b = in.r2;
`ifdef EX_FORWARD_EN
    if (prev.we && prev.rd != 0 && prev.rd == in.a1) a = prev.d;
    if (prev.we && prev.rd != 0 && prev.rd == in.a2) b = prev.d;
`else
    if (prev.we === 1'bx) a = 'x;
`endif
    e.d   = alu_ref(in.op, a, b, in.imm);
    e.st  = b;
    e.ctl = (in.ctl == 2'b10) ? 2'b10 : (in.ctl == 2'b01) ? 2'b01 : 2'b00;
    e.we  = in.we;
    e.rd  = in.rd;
    return e;
  endfunction

  task automatic drive(input instr_t in);
    dataReg1 = in.r1; dataReg2 = in.r2; immValueIn = in.imm;
    dataS1AddrIn = in.a1; dataS2AddrIn = in.a2; writeBackAddrIn = in.rd;
    ALUop = in.op; dataCacheControlIn = in.ctl; writeEnableReg = in.we;
  endtask

  task automatic issue(input instr_t in);
    drive(in);
    @(posedge clk); #1;
  endtask

  function automatic instr_t mk(input logic [31:0] r1, r2, imm, input logic [4:0] a1, a2, rd,
                                input logic [3:0] op, input logic [1:0] ctl, input logic we);
    instr_t t;
    t.r1 = r1; t.r2 = r2; t.imm = imm; t.a1 = a1; t.a2 = a2; t.rd = rd;
    t.op = op; t.ctl = ctl; t.we = we;
    return t;
  endfunction

  function automatic instr_t idle();
    return mk(0, 0, 0, 0, 0, 0, 4'h0, 2'b00, 1'b0);
  endfunction

  task automatic test_reset();
    resetN = 1'b0;
    drive(mk($urandom, $urandom, $urandom, 5'd7, 5'd9, 5'd3, 4'h0, 2'b10, 1'b1));
    #1;
    n_checks++;
    if ({dataOut, dataRs2Out, dataCacheControlOut, writeEnableOut, writeBackAddrOut} !== '0) begin
      n_fail++;
      $display("FAIL reset_initial: got d=%h st=%h c=%b we=%b rd=%0d, want all zero",
               dataOut, dataRs2Out, dataCacheControlOut, writeEnableOut, writeBackAddrOut);
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({dataOut, writeEnableOut} !== '0) begin
      n_fail++;
      $display("FAIL reset_held: got d=%h we=%b, want 0", dataOut, writeEnableOut);
    end
    drive(idle());
    resetN = 1'b1;
    issue(idle());
    issue(idle());
    // Load some state, then check the asynchronous clear lands between edges.
    issue(mk(32'h11, 32'h22, 0, 0, 0, 5'd4, 4'h0, 2'b01, 1'b1));
    issue(idle());
    #2 resetN = 1'b0;
    #1;
    n_checks++;
    if ({dataOut, dataRs2Out, dataCacheControlOut, writeEnableOut, writeBackAddrOut} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got d=%h st=%h c=%b we=%b rd=%0d, want all zero",
               dataOut, dataRs2Out, dataCacheControlOut, writeEnableOut, writeBackAddrOut);
    end
    @(negedge clk);
    resetN = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    issue(idle());
    issue(mk(5, 7, 0, 0, 0, 5'd3, 4'h0, 2'b00, 1'b1));
    n_checks++;
    if (writeEnableOut !== 1'b0) begin
      n_fail++;
      $display("FAIL add_latency: we after one edge=%b, want 0", writeEnableOut);
    end
    issue(idle());
    n_checks++;
    if (dataOut !== 32'd12 || writeBackAddrOut !== 5'd3 || writeEnableOut !== 1'b1) begin
      n_fail++;
      $display("FAIL add: got d=%0d rd=%0d we=%b, want d=12 rd=3 we=1",
               dataOut, writeBackAddrOut, writeEnableOut);
    end
  endtask

  task automatic test_alu_vectors();
    instr_t v[4];
    logic [31:0] want[4];
    v[0] = mk(0, 1, 0, 0, 0, 0, 4'h1, 2'b00, 1'b0);            want[0] = 32'hFFFFFFFF;
    v[1] = mk(32'h80000000, 4, 0, 0, 0, 0, 4'h7, 2'b00, 1'b0); want[1] = 32'hF8000000;
    v[2] = mk(1, 32'hFFFFFFFF, 0, 0, 0, 0, 4'h9, 2'b00, 1'b0); want[2] = 32'd1;
    v[3] = mk(1, 32'hFFFFFFFF, 0, 0, 0, 0, 4'h8, 2'b00, 1'b0); want[3] = 32'd0;
    for (int k = 0; k < 4; k++) begin
      issue(v[k]);
      issue(idle());
      n_checks++;
      if (dataOut !== want[k]) begin
        n_fail++;
        $display("FAIL alu_vec%0d op=%h: got %h, want %h", k, v[k].op, dataOut, want[k]);
      end
    end
  endtask

  task automatic test_store();
    issue(mk(32'h8, 32'hAB, 32'h3, 0, 0, 0, 4'hA, 2'b10, 1'b0));
    issue(idle());
    n_checks++;
    if (dataOut !== 32'hB || dataRs2Out !== 32'hAB || dataCacheControlOut !== 2'b10) begin
      n_fail++;
      $display("FAIL store: got d=%h st=%h c=%b, want d=b st=ab c=10",
               dataOut, dataRs2Out, dataCacheControlOut);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] want2;
`ifdef EX_FORWARD_EN
    want2 = 32'd13;
`else
    want2 = 32'd1;
`endif
    issue(idle());
    issue(mk(5, 7, 0, 0, 0, 5'd1, 4'h0, 2'b00, 1'b1));
    issue(mk(0, 1, 0, 5'd1, 0, 5'd2, 4'h0, 2'b00, 1'b1));
    n_checks++;
    if (dataOut !== 32'd12) begin
      n_fail++;
      $display("FAIL b2b_first: got %0d, want 12", dataOut);
    end
    issue(idle());
    n_checks++;
    if (dataOut !== want2 || writeBackAddrOut !== 5'd2) begin
      n_fail++;
      $display("FAIL b2b_second: got d=%0d rd=%0d, want d=%0d rd=2", dataOut, writeBackAddrOut, want2);
    end
  endtask

  task automatic test_mid_reset();
    issue(idle());
    issue(mk(5, 7, 0, 0, 0, 5'd3, 4'h0, 2'b00, 1'b1));
    drive(idle());
    #2 resetN = 1'b0;
    #2 resetN = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (writeEnableOut !== 1'b0 || dataOut !== 32'd0) begin
        n_fail++;
        $display("FAIL mid_reset cyc%0d: got we=%b d=%0d, want we=0 d=0", k, writeEnableOut, dataOut);
      end
    end
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t prev, e, got;
    instr_t in;
    resetN = 1'b0;
    drive(idle());
    #2 resetN = 1'b1;
    @(posedge clk); #1;
    prev.d = 0; prev.st = 0; prev.ctl = 0; prev.we = 0; prev.rd = 0;
    for (int t = 0; t < 400; t++) begin
      in = mk($urandom, $urandom, $urandom, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 4'($urandom), 2'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) in.r2 = 32'($urandom_range(0, 40));
      e = predict(in, prev);
      prev = e;
      q.push_back(e);
      issue(in);
      if (q.size() == 2) begin
        e = q.pop_front();
        got.d = dataOut; got.st = dataRs2Out; got.ctl = dataCacheControlOut;
        got.we = writeEnableOut; got.rd = writeBackAddrOut;
        n_checks++;
        if (got.d !== e.d || got.st !== e.st || got.ctl !== e.ctl || got.we !== e.we || got.rd !== e.rd) begin
          n_fail++;
          $display("FAIL random t=%0d: got d=%h st=%h c=%b we=%b rd=%0d, want d=%h st=%h c=%b we=%b rd=%0d",
                   t, got.d, got.st, got.ctl, got.we, got.rd, e.d, e.st, e.ctl, e.we, e.rd);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_vectors();
    test_store();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
